// File: rtl/ft2_xfer_arbiter.sv
// FT2 half-duplex channel arbiter: shares the byte mover between the outbound sample
// stream and inbound command bytes with burst-limited round robin and a request timeout.
module ft2_xfer_arbiter #(
    parameter int unsigned WR_BURST = 16,
    parameter int unsigned RD_BURST = 4,
    parameter int unsigned TIMEOUT  = 255
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic       txe_avail,
    input  logic       rxf_avail,
    input  logic       tx_valid,
    input  logic [7:0] tx_data,
    output logic       tx_ready,
    input  logic       rx_space,
    output logic       rx_valid,
    output logic [7:0] rx_data,
    output logic       mv_wr_en,
    output logic       mv_rd_en,
    output logic [7:0] mv_write_data,
    input  logic       mv_data_sent,
    input  logic       mv_data_ready,
    input  logic [7:0] mv_read_data,
    output logic       timeout_err,
    input  logic       clr_err
);
    typedef enum logic [1:0] {IDLE = 2'd0, WR_REQ = 2'd1, RD_REQ = 2'd2} state_e;
    typedef enum logic {XFER_READ = 1'b0, XFER_WRITE = 1'b1} xfer_e;

    localparam logic [7:0]  WR_LIMIT   = 8'(WR_BURST);
    localparam logic [7:0]  RD_LIMIT   = 8'(RD_BURST);
    localparam logic [15:0] TIMER_LAST = 16'(TIMEOUT - 1);

    state_e      state_q, state_d;
    xfer_e       last_q, last_d;
    logic [7:0]  streak_q, streak_d;
    logic [15:0] timer_q, timer_d;
    logic [7:0]  hold_byte_q, hold_byte_d;
    logic        hold_valid_q, hold_valid_d;
    logic        tx_ready_q, tx_ready_d;
    logic        rx_valid_q, rx_valid_d;
    logic [7:0]  rx_data_q, rx_data_d;
    logic        mv_wr_en_q, mv_wr_en_d;
    logic        mv_rd_en_q, mv_rd_en_d;
    logic [7:0]  mv_write_data_q, mv_write_data_d;
    logic        timeout_err_q, timeout_err_d;
    logic        wr_cand, rd_cand, grant_wr, grant_rd, timeout_hit;

    always_comb begin
        // NOTE: every variable gets its hold/idle value first so no path can infer a latch.
        state_d         = state_q;
        last_d          = last_q;
        streak_d        = streak_q;
        timer_d         = timer_q;
        hold_byte_d     = hold_byte_q;
        hold_valid_d    = hold_valid_q;
        tx_ready_d      = 1'b0;
        rx_valid_d      = mv_data_ready;
        rx_data_d       = mv_data_ready ? mv_read_data : rx_data_q;
        mv_wr_en_d      = mv_wr_en_q;
        mv_rd_en_d      = mv_rd_en_q;
        mv_write_data_d = mv_write_data_q;
        timeout_hit     = 1'b0;
        grant_wr        = 1'b0;
        grant_rd        = 1'b0;
        wr_cand         = en & txe_avail & (hold_valid_q | tx_valid);
        rd_cand         = en & rxf_avail & rx_space;

        case (state_q)
            IDLE: begin
                // Contention keeps the current direction until its burst budget is spent.
                if (wr_cand && rd_cand) begin
                    if (last_q == XFER_WRITE) grant_wr = (streak_q < WR_LIMIT);
                    else                      grant_wr = (streak_q >= RD_LIMIT);
                    grant_rd = ~grant_wr;
                end else begin
                    grant_wr = wr_cand;
                    grant_rd = rd_cand;
                end

                if (grant_wr) begin
                    state_d    = WR_REQ;
                    mv_wr_en_d = 1'b1;
                    timer_d    = '0;
                    if (hold_valid_q) begin
                        mv_write_data_d = hold_byte_q;
                    end else begin
                        hold_byte_d     = tx_data;
                        hold_valid_d    = 1'b1;
                        tx_ready_d      = 1'b1;
                        mv_write_data_d = tx_data;
                    end
                    if (last_q == XFER_WRITE) begin
                        streak_d = (streak_q == 8'hFF) ? streak_q : streak_q + 8'd1;
                    end else begin
                        streak_d = 8'd1;
                        last_d   = XFER_WRITE;
                    end
                end else if (grant_rd) begin
                    state_d    = RD_REQ;
                    mv_rd_en_d = 1'b1;
                    timer_d    = '0;
                    if (last_q == XFER_READ) begin
                        streak_d = (streak_q == 8'hFF) ? streak_q : streak_q + 8'd1;
                    end else begin
                        streak_d = 8'd1;
                        last_d   = XFER_READ;
                    end
                end
            end

            WR_REQ: begin
                if (mv_data_sent) begin
                    mv_wr_en_d   = 1'b0;
                    hold_valid_d = 1'b0;
                    state_d      = IDLE;
                end else if (timer_q == TIMER_LAST) begin
                    mv_wr_en_d  = 1'b0;
                    timeout_hit = 1'b1;
                    state_d     = IDLE;
                end else begin
                    timer_d = timer_q + 16'd1;
                end
            end

            RD_REQ: begin
                if (mv_data_ready) begin
                    mv_rd_en_d = 1'b0;
                    state_d    = IDLE;
                end else if (timer_q == TIMER_LAST) begin
                    mv_rd_en_d  = 1'b0;
                    timeout_hit = 1'b1;
                    state_d     = IDLE;
                end else begin
                    timer_d = timer_q + 16'd1;
                end
            end

            default: state_d = IDLE;
        endcase

        timeout_err_d = (timeout_err_q & ~clr_err) | timeout_hit;
    end

    // NOTE: registers use non-blocking assignments so all of them sample pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q         <= IDLE;
            last_q          <= XFER_WRITE;
            streak_q        <= '0;
            timer_q         <= '0;
            hold_byte_q     <= '0;
            hold_valid_q    <= 1'b0;
            tx_ready_q      <= 1'b0;
            rx_valid_q      <= 1'b0;
            rx_data_q       <= '0;
            mv_wr_en_q      <= 1'b0;
            mv_rd_en_q      <= 1'b0;
            mv_write_data_q <= '0;
            timeout_err_q   <= 1'b0;
        end else begin
            state_q         <= state_d;
            last_q          <= last_d;
            streak_q        <= streak_d;
            timer_q         <= timer_d;
            hold_byte_q     <= hold_byte_d;
            hold_valid_q    <= hold_valid_d;
            tx_ready_q      <= tx_ready_d;
            rx_valid_q      <= rx_valid_d;
            rx_data_q       <= rx_data_d;
            mv_wr_en_q      <= mv_wr_en_d;
            mv_rd_en_q      <= mv_rd_en_d;
            mv_write_data_q <= mv_write_data_d;
            timeout_err_q   <= timeout_err_d;
        end
    end

    assign tx_ready      = tx_ready_q;
    assign rx_valid      = rx_valid_q;
    assign rx_data       = rx_data_q;
    assign mv_wr_en      = mv_wr_en_q;
    assign mv_rd_en      = mv_rd_en_q;
    assign mv_write_data = mv_write_data_q;
    assign timeout_err   = timeout_err_q;
endmodule
